priority_encoder: RTL and testbench

PRIORITY_ENCODER -- requirements
Module: priority_encoder

---
 rtl/priority_encoder.sv | 51 +++++
 tb/tb_priority_encoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// Registered MSB-first priority encoder: binary index, valid flag and one-hot form
// of the highest set request bit, loaded when en is high.
module priority_encoder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned YW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [YW-1:0]    y,
    output logic             valid,
    output logic [WIDTH-1:0] y_onehot
);

    logic [YW-1:0]    idx;
    logic             hit;
    logic [WIDTH-1:0] onehot;

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                idx = YW'(i);
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        onehot = '0;
        if (hit) begin
            onehot = WIDTH'(1) << idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= '0;
            valid    <= 1'b0;
            y_onehot <= '0;
        end else if (en) begin
            y        <= idx;
            valid    <= hit;
            y_onehot <= onehot;
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder: stimulus queues expected results, a
// monitor pops one per enabled edge and compares the registered outputs.
module tb_priority_encoder;

    typedef struct {
        logic [3:0]  y;
        logic        v;
        logic [15:0] oh;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] d;
    logic [3:0]  y;
    logic        valid;
    logic [15:0] y_onehot;

    exp_t exp_q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    priority_encoder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .d        (d),
        .y        (y),
        .valid    (valid),
        .y_onehot (y_onehot)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input exp_t e);
        checks++;
        if (y !== e.y || valid !== e.v || y_onehot !== e.oh) begin
            errors++;
            $display("FAIL %s: got y=%0d valid=%0b onehot=%h, expected y=%0d valid=%0b onehot=%h",
                     name, y, valid, y_onehot, e.y, e.v, e.oh);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] ey, input logic ev);
        exp_t e;
        e.y  = ey;
        e.v  = ev;
        e.oh = ev ? (16'd1 << ey) : 16'd0;
        return e;
    endfunction

    // Apply one cycle of stimulus; an enabled sample queues its expected result.
    task automatic drive(input logic ien, input logic [15:0] id,
                         input logic [3:0] ey, input logic ev);
        en = ien;
        d  = id;
        if (ien) exp_q.push_back(mk(ey, ev));
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic e, r;
        last = mk(4'd0, 1'b0);
        forever begin
            @(posedge clk);
            e = en;
            r = rst_n;
            #1;
            if (!r) begin
                last = mk(4'd0, 1'b0);
                compare("reset_hold", last);
            end else if (e) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got unexpected load y=%0d, expected no sample pending", y);
                end else begin
                    last = exp_q.pop_front();
                    compare("load", last);
                end
            end else begin
                compare("hold", last);
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        en    = 1'b0;
        d     = 16'h0000;
        #2;
        compare("reset_initial", mk(4'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 16'h0000, 4'd0,  1'b0);
        drive(1'b1, 16'h0100, 4'd8,  1'b1);
        drive(1'b1, 16'hFFFF, 4'd15, 1'b1);
        drive(1'b1, 16'h0001, 4'd0,  1'b1);
        drive(1'b1, 16'h7FFF, 4'd14, 1'b1);
        drive(1'b1, 16'h0002, 4'd1,  1'b1);
        drive(1'b1, 16'h8001, 4'd15, 1'b1);
        drive(1'b1, 16'h00F0, 4'd7,  1'b1);
        drive(1'b1, 16'h1234, 4'd12, 1'b1);
        drive(1'b1, 16'h0400, 4'd10, 1'b1);
        drive(1'b1, 16'h0081, 4'd7,  1'b1);
        drive(1'b1, 16'h4000, 4'd14, 1'b1);
        drive(1'b1, 16'h0003, 4'd1,  1'b1);
        drive(1'b1, 16'h2000, 4'd13, 1'b1);
        drive(1'b1, 16'h0000, 4'd0,  1'b0);

        drive(1'b1, 16'h0A30, 4'd11, 1'b1);
        drive(1'b0, 16'h8000, 4'd0,  1'b0);
        drive(1'b0, 16'h0000, 4'd0,  1'b0);

        // Asynchronous reset between edges must clear the held result at once.
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_reset", mk(4'd0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 16'hFFFF, 4'd0, 1'b0);
        drive(1'b1, 16'h0020, 4'd5, 1'b1);
        drive(1'b0, 16'h0000, 4'd0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
